// File: rtl/wide_to_narrow_ser_if.sv
// Word-in / beat-out handshake bundle for wide_to_narrow_ser.
// out_parity exists only when WIDE_TO_NARROW_SER_PARITY_EN is defined.
interface wide_to_narrow_ser_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  data_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] data_out;
  logic             out_last;
  logic             busy;
`ifdef WIDE_TO_NARROW_SER_PARITY_EN
  logic             out_parity;
`endif

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, out_last, busy
`ifdef WIDE_TO_NARROW_SER_PARITY_EN
    , output out_parity
`endif
  );

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, out_last, busy
`ifdef WIDE_TO_NARROW_SER_PARITY_EN
    , input out_parity
`endif
  );
endinterface

// File: rtl/wide_to_narrow_ser.sv
// Splits IN_W words into IN_W/OUT_W beats with a one-word skid register.
// Optional beat parity output: define WIDE_TO_NARROW_SER_PARITY_EN.
module wide_to_narrow_ser #(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic               div_8_clk,
  input  logic               rst_n,
  wide_to_narrow_ser_if.slave bus
);
  localparam int N     = IN_W / OUT_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            r_state, w_nxt_state;
  logic [IDX_W-1:0]  r_idx, w_nxt_idx;
  logic [IN_W-1:0]   r_shift, w_nxt_shift;
  logic [IN_W-1:0]   r_pend, w_nxt_pend;
  logic              r_pend_vld, w_nxt_pend_vld;
  logic              r_in_ready;

  logic [N-1:0][OUT_W-1:0] w_beats;
  logic w_in_xfer, w_out_xfer, w_last, w_out_valid;

  // Beat k in transmit order, independent of MSB_FIRST downstream
  for (genvar k = 0; k < N; k++) begin : g_beat
    if (MSB_FIRST != 0) begin : g_msb
      assign w_beats[k] = r_shift[(N-1-k)*OUT_W +: OUT_W];
    end else begin : g_lsb
      assign w_beats[k] = r_shift[k*OUT_W +: OUT_W];
    end
  end

  assign w_out_valid = (r_state == SHIFT);
  assign w_last      = (r_idx == IDX_W'(N-1));
  assign w_in_xfer   = bus.in_valid && r_in_ready;
  assign w_out_xfer  = w_out_valid && bus.out_ready;

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_idx      = r_idx;
    w_nxt_shift    = r_shift;
    w_nxt_pend     = r_pend;
    w_nxt_pend_vld = r_pend_vld;
    unique case (r_state)
      IDLE: begin
        if (w_in_xfer) begin
          w_nxt_shift = bus.data_in;
          w_nxt_idx   = '0;
          w_nxt_state = SHIFT;
        end
      end
      SHIFT: begin
        if (w_out_xfer && w_last) begin
          w_nxt_idx = '0;
          if (r_pend_vld) begin
            w_nxt_shift    = r_pend;
            w_nxt_pend_vld = 1'b0;
          end else if (w_in_xfer) begin
            w_nxt_shift = bus.data_in;
          end else begin
            w_nxt_state = IDLE;
          end
        end else begin
          if (w_out_xfer)
            w_nxt_idx = r_idx + IDX_W'(1);
          // Any other accepted word is parked until the current one drains
          if (w_in_xfer) begin
            w_nxt_pend     = bus.data_in;
            w_nxt_pend_vld = 1'b1;
          end
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge div_8_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_shift    <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_idx      <= w_nxt_idx;
      r_shift    <= w_nxt_shift;
      r_pend     <= w_nxt_pend;
      r_pend_vld <= w_nxt_pend_vld;
      r_in_ready <= !w_nxt_pend_vld;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.data_out  = w_out_valid ? w_beats[r_idx] : '0;
  assign bus.out_last  = w_out_valid && w_last;
  assign bus.busy      = w_out_valid || r_pend_vld;

`ifdef WIDE_TO_NARROW_SER_PARITY_EN
  logic [N-1:0][OUT_W-1:0] w_nxt_beats;
  logic                    r_parity;

  for (genvar k = 0; k < N; k++) begin : g_nxt_beat
    if (MSB_FIRST != 0) begin : g_msb
      assign w_nxt_beats[k] = w_nxt_shift[(N-1-k)*OUT_W +: OUT_W];
    end else begin : g_lsb
      assign w_nxt_beats[k] = w_nxt_shift[k*OUT_W +: OUT_W];
    end
  end

  // Parity is computed from the beat that will be presented next cycle
  always_ff @(posedge div_8_clk or negedge rst_n) begin
    if (!rst_n)
      r_parity <= 1'b0;
    else
      r_parity <= (w_nxt_state == SHIFT) ? ^w_nxt_beats[w_nxt_idx] : 1'b0;
  end

  assign bus.out_parity = r_parity;
`endif

endmodule

// File: doc/wide_to_narrow_ser.md
WIDE_TO_NARROW_SER -- requirements
Module: wide_to_narrow_ser

Interface
REQ-001 SHALL have parameter IN_W, default 32, input word width.
REQ-002 SHALL have parameter OUT_W, default 8, output beat width; IN_W SHALL be an integer multiple of OUT_W, with IN_W/OUT_W >= 2.
REQ-003 SHALL have parameter MSB_FIRST, default 0; 0 = least-significant beat first, 1 = most-significant beat first.
REQ-004 SHALL have port div_8_clk, input, 1, clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1, data_in holds a word to load.
REQ-007 SHALL have port in_ready, output, 1, block can accept a word.
REQ-008 SHALL have port data_in, input, IN_W, parallel word.
REQ-009 SHALL have port out_valid, output, 1, data_out holds a valid beat.
REQ-010 SHALL have port out_ready, input, 1, sink accepts the beat.
REQ-011 SHALL have port data_out, output, OUT_W, current beat.
REQ-012 SHALL have port out_last, output, 1, current beat is the final beat of its word.
REQ-013 SHALL have port busy, output, 1, a word is being serialised or is pending.

Function
REQ-014 SHALL define input transfer as in_valid && in_ready at a rising edge, and output transfer as out_valid && out_ready at a rising edge.
REQ-015 SHALL hold a shift register (one word) and a one-entry pending register with a pend_vld flag.
REQ-016 SHALL drive in_ready = !pend_vld, registered, with no combinational path from in_valid or out_ready.
REQ-017 SHALL implement states IDLE (shift register empty) and SHIFT (beat index 0..N-1 active, N = IN_W/OUT_W).
REQ-018 IDLE: on input transfer, load the word into the shift register, beat index 0, go to SHIFT; out_valid SHALL be high on the next cycle (1-cycle latency).
REQ-019 SHIFT: on output transfer at beat index < N-1, advance to the next beat; with no output transfer, data_out, out_last and the index SHALL hold.
REQ-020 SHIFT: on output transfer at beat N-1 with pend_vld = 1, load the pending word, index 0, clear pend_vld, and stay in SHIFT, with no idle bubble.
REQ-021 SHIFT: on output transfer at beat N-1 with pend_vld = 0 and no simultaneous input transfer, go to IDLE with out_valid low.
REQ-022 SHIFT: on output transfer at beat N-1 with pend_vld = 0 and a simultaneous input transfer, load data_in directly into the shift register and stay in SHIFT.
REQ-023 SHIFT: an input transfer that does not coincide with a last-beat output transfer SHALL fill the pending register and set pend_vld.
REQ-024 data_out SHALL select beat k as bits [k*OUT_W +: OUT_W] when MSB_FIRST = 0 and bits [(N-1-k)*OUT_W +: OUT_W] when MSB_FIRST = 1.
REQ-025 out_last SHALL be high exactly when out_valid is high and the beat index is N-1.
REQ-026 busy SHALL equal (state == SHIFT) || pend_vld.
REQ-027 All outputs SHALL be register-driven or a mux from registered state only; data_out SHALL be 0 whenever out_valid is low.

Reset
REQ-028 Asserting rst_n low SHALL asynchronously force IDLE, beat index 0, pend_vld 0, out_valid 0, out_last 0, busy 0, data_out 0, and in_ready 0.
REQ-029 in_ready SHALL rise on the first rising edge after reset deassertion.
REQ-030 A reset asserted mid-word SHALL discard the shift and pending contents, and no beat of them SHALL appear afterwards.

Configuration
REQ-031 When macro WIDE_TO_NARROW_SER_PARITY_EN is defined, the block SHALL add output out_parity (1 bit) equal to the even parity (XOR) of data_out, registered with the beat, 0 in reset and while out_valid is low.
REQ-032 When WIDE_TO_NARROW_SER_PARITY_EN is undefined, port out_parity and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-033 Defaults, out_ready = 1, single word 0x44332211 -> beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles, out_last only on 0x44, then IDLE.
REQ-034 MSB_FIRST = 1, word 0xA1B2C3D4 -> beats 0xA1, 0xB2, 0xC3, 0xD4.
REQ-035 in_valid held high with words 0x03020100 then 0x07060504 -> 8 beats 0x00..0x07 with no gap, and in_ready low while pend_vld = 1.
REQ-036 out_ready low for 3 cycles at beat 1 of 0xDDCCBBAA -> data_out holds 0xBB, stable, for all 3 cycles, then the sequence resumes.
REQ-037 Pulse rst_n low after beat 0x22 of 0x44332211 -> outputs zero immediately, no further beats, in_ready high on the first edge after release.
REQ-038 With WIDE_TO_NARROW_SER_PARITY_EN defined, word 0x0F070301 -> out_parity 1, 0, 1, 0.
